// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle add/sub/or/slt, bit-serial shifts and a
// shift-add multiplier, driven by a two-state IDLE/EXEC controller.
module ula_multiciclo #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [2:0]       sinal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Bus,
  output logic [WIDTH-1:0] G,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];
  localparam logic [SHW-1:0]   CNT_W   = SHW'(WIDTH);
  localparam logic [SHW-1:0]   CNT_MUL = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] g_q;
  logic             zero_q, carry_q, ovf_q, done_q;

  logic             accept;
  logic             finish;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] shift_step, acc_step;
  logic [WIDTH-1:0] res;
  logic             res_carry, res_ovf;

  assign accept = (state_q == S_IDLE) && start;
  // Every operation ends on the EXEC cycle whose counter reads zero.
  assign finish = (state_q == S_EXEC) && (cnt_q == '0);
  assign shamt  = (Bus >= WIDTH_V) ? CNT_W : Bus[SHW-1:0];

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)  state_d = S_EXEC;
      S_EXEC:  if (finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == S_EXEC);
    done  = done_q;
    G     = g_q;
    zero  = zero_q;
    carry = carry_q;
    ovf   = ovf_q;
  end

  always_comb begin
    sum_ext  = {1'b0, opa_q} + {1'b0, opb_q};
    diff_ext = {1'b0, opa_q} - {1'b0, opb_q};
    acc_step = acc_q + (opb_q[0] ? opa_q : '0);
    case (op_q)
      OP_SLL:  shift_step = {opa_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, opa_q[WIDTH-1:1]};
      default: shift_step = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res       = sum_ext[WIDTH-1:0];
        res_carry = sum_ext[WIDTH];
        res_ovf   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OP_SUB: begin
        res       = diff_ext[WIDTH-1:0];
        res_carry = diff_ext[WIDTH];
        res_ovf   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OP_OR:   res = opa_q | opb_q;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OP_MUL:  res = acc_step;
      default: res = opa_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      op_q    <= OP_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q  <= sinal;
        opa_q <= A;
        opb_q <= Bus;
        acc_q <= '0;
        case (sinal)
          OP_SLL, OP_SRL, OP_SRA: cnt_q <= shamt;
          OP_MUL:                 cnt_q <= CNT_MUL;
          default:                cnt_q <= '0;
        endcase
      end else if (finish) begin
        g_q     <= res;
        zero_q  <= (res == '0);
        carry_q <= res_carry;
        ovf_q   <= res_ovf;
        done_q  <= 1'b1;
      end else if (state_q == S_EXEC) begin
        cnt_q <= cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          acc_q <= acc_step;
          opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          opb_q <= {1'b0, opb_q[WIDTH-1:1]};
        end else begin
          opa_q <= shift_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized and directed bench for ula_multiciclo against an arithmetic
// reference model of results, flags and latency.
module tb_ula_multiciclo;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        start;
  logic [2:0]  sinal;
  logic [15:0] A, Bus;
  logic [15:0] G;
  logic        busy, done, zero, carry, ovf;

  int checks = 0;
  int errors = 0;

  ula_multiciclo #(.WIDTH(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .sinal(sinal),
    .A(A), .Bus(Bus), .G(G), .busy(busy), .done(done),
    .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 Clock = ~Clock;

  // Reference: results from plain integer arithmetic, latency from the op rules.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, b,
                                output logic [15:0] g, output logic c, v,
                                output int lat);
    int sa, sb, r, n;
    logic [31:0] w;
    sa = $signed(a);
    sb = $signed(b);
    n  = (b >= 16'd16) ? 16 : int'(b);
    c = 1'b0; v = 1'b0; lat = 1; g = '0; r = 0; w = '0;
    case (op)
      3'd0: begin
        w = 32'(a) + 32'(b); g = w[15:0]; c = (w > 32'h0000FFFF);
        r = sa + sb; v = (r > 32767) || (r < -32768);
      end
      3'd1: begin
        w = 32'(a) - 32'(b); g = w[15:0]; c = (a < b);
        r = sa - sb; v = (r > 32767) || (r < -32768);
      end
      3'd2: g = a | b;
      3'd3: g = (a < b) ? 16'd1 : 16'd0;
      3'd4: begin w = 32'(a) << n; g = w[15:0]; lat = n + 1; end
      3'd5: begin w = 32'(a) >> n; g = w[15:0]; lat = n + 1; end
      3'd6: begin r = sa >>> n; g = r[15:0]; lat = n + 1; end
      default: begin w = 32'(a) * 32'(b); g = w[15:0]; lat = 16; end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, b,
                       output int lat, output bit to, output bit busy_ok);
    start = 1'b1; sinal = op; A = a; Bus = b;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0; sinal = 3'($urandom); A = 16'($urandom); Bus = 16'($urandom);
    busy_ok = (busy === 1'b1);
    lat = 0; to = 1'b0;
    while (1) begin
      @(posedge Clock);
      lat++;
      @(negedge Clock);
      if (done === 1'b1) break;
      if (lat >= 200) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0; start = 1'b1; sinal = 3'd0; A = 16'h1234; Bus = 16'h0001;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({G, busy, done, zero, carry, ovf} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got G=%h busy=%b done=%b zero=%b carry=%b ovf=%b, want all 0",
               G, busy, done, zero, carry, ovf);
    end
    Resetn = 1'b1; start = 1'b0;
    $display("txn reset: G=%h busy=%b done=%b", G, busy, done);
  endtask

  task automatic test_directed();
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [15:0] as  [8] = '{16'hFFFF, 16'h8000, 16'd3, 16'h0001, 16'h0001, 16'h8000, 16'hABCD, 16'h0100};
    logic [15:0] bs  [8] = '{16'h0001, 16'h0001, 16'd5, 16'd4, 16'd20, 16'd15, 16'd0, 16'h0101};
    logic [15:0] gs  [8] = '{16'h0000, 16'h7FFF, 16'h0001, 16'h0010, 16'h0000, 16'hFFFF, 16'hABCD, 16'h0100};
    logic [2:0]  fl  [8] = '{3'b110, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    int          ls  [8] = '{1, 1, 1, 5, 17, 16, 1, 16};
    int lat; bit to, bok;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], lat, to, bok);
      checks++;
      if (to || lat != ls[i] || !bok) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got lat=%0d timeout=%b busy_ok=%b, want lat=%0d",
                 i, lat, to, bok, ls[i]);
      end
      checks++;
      if ({G, zero, carry, ovf} !== {gs[i], fl[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: got G=%h zco=%b%b%b, want G=%h zco=%b",
                 i, G, zero, carry, ovf, gs[i], fl[i]);
      end
      $display("txn directed op=%0d A=%h Bus=%h G=%h lat=%0d", ops[i], as[i], bs[i], G, lat);
      @(negedge Clock);
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [15:0] a, b, eg; logic ec, ev;
    int elat, lat; bit to, bok;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = (op inside {3'd4, 3'd5, 3'd6} && $urandom_range(0, 3) != 0)
           ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (op == 3'd1 && $urandom_range(0, 3) == 0) b = a;
      model(op, a, b, eg, ec, ev, elat);
      do_op(op, a, b, lat, to, bok);
      checks++;
      if (to || lat != elat || !bok) begin
        errors++;
        $display("FAIL random_latency[%0d]: op=%0d got lat=%0d timeout=%b busy_ok=%b, want lat=%0d",
                 i, op, lat, to, bok, elat);
      end
      checks++;
      if ({G, zero, carry, ovf} !== {eg, (eg == 16'd0), ec, ev}) begin
        errors++;
        $display("FAIL random_result[%0d]: op=%0d A=%h Bus=%h got G=%h z=%b c=%b v=%b, want G=%h z=%b c=%b v=%b",
                 i, op, a, b, G, zero, carry, ovf, eg, (eg == 16'd0), ec, ev);
      end
      $display("txn random op=%0d A=%h Bus=%h G=%h lat=%0d", op, a, b, G, lat);
      A = 16'($urandom); Bus = 16'($urandom); sinal = 3'($urandom);
      @(posedge Clock);
      @(negedge Clock);
      checks++;
      if ({done, busy, G, zero, carry, ovf} !== {2'b00, eg, (eg == 16'd0), ec, ev}) begin
        errors++;
        $display("FAIL random_hold[%0d]: got done=%b busy=%b G=%h, want done=0 busy=0 G=%h",
                 i, done, busy, G, eg);
      end
    end
  endtask

  task automatic test_ignore_start();
    int e;
    bit busy_ok = 1'b1;
    start = 1'b1; sinal = 3'd7; A = 16'h0100; Bus = 16'h0101;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    e = 0;
    while (e < 200) begin
      @(posedge Clock);
      e++;
      @(negedge Clock);
      if (e == 4) begin start = 1'b1; sinal = 3'd0; A = 16'h0003; Bus = 16'h0004; end
      if (e == 5) start = 1'b0;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    checks++;
    if (e != 16 || !busy_ok) begin
      errors++;
      $display("FAIL ignore_start_latency: got lat=%0d busy_ok=%b, want lat=16 busy_ok=1", e, busy_ok);
    end
    checks++;
    if (G !== 16'h0100) begin
      errors++;
      $display("FAIL ignore_start_result: got G=%h, want G=0100", G);
    end
    $display("txn ignore_start mul G=%h lat=%0d", G, e);
    @(negedge Clock);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, eg; logic ec, ev; int elat, lat; bit to, bok;
    a = 16'($urandom); b = 16'($urandom);
    model(3'd7, a, b, eg, ec, ev, elat);
    do_op(3'd7, a, b, lat, to, bok);
    checks++;
    if (to || G !== eg) begin
      errors++;
      $display("FAIL b2b_first: got G=%h timeout=%b, want G=%h", G, to, eg);
    end
    a = 16'($urandom); b = 16'($urandom);
    model(3'd0, a, b, eg, ec, ev, elat);
    do_op(3'd0, a, b, lat, to, bok);
    checks++;
    if (to || lat != 1 || !bok) begin
      errors++;
      $display("FAIL b2b_latency: got lat=%0d busy_ok=%b, want lat=1 busy_ok=1", lat, bok);
    end
    checks++;
    if ({G, carry, ovf} !== {eg, ec, ev}) begin
      errors++;
      $display("FAIL b2b_result: got G=%h c=%b v=%b, want G=%h c=%b v=%b", G, carry, ovf, eg, ec, ev);
    end
    $display("txn back_to_back add A=%h Bus=%h G=%h lat=%0d", a, b, G, lat);
    @(negedge Clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_reset_abort();
    bit early_done = 1'b0;
    start = 1'b1; sinal = 3'd7; A = 16'h1234; Bus = 16'h5678;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (done === 1'b1) early_done = 1'b1;
    end
    Resetn = 1'b0; start = 1'b1; sinal = 3'd0; A = 16'h0001; Bus = 16'h0001;
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({G, busy, done, zero, carry, ovf} !== 21'd0 || early_done) begin
      errors++;
      $display("FAIL reset_abort: got G=%h busy=%b done=%b zco=%b%b%b early_done=%b, want all 0",
               G, busy, done, zero, carry, ovf, early_done);
    end
    Resetn = 1'b1; start = 1'b1; sinal = 3'd0; A = 16'h0002; Bus = 16'h0002;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (done !== 1'b1 || G !== 16'h0004 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_result: got done=%b G=%h busy=%b, want done=1 G=0004 busy=0",
               done, G, busy);
    end
    $display("txn reset_abort then add 2+2 G=%h", G);
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
